// File: rtl/ins_pkg.sv
// Shared definitions for the insertion-sort front end (loader and sorter).
// Frame geometry, loader state encoding and slot decode helpers.
package ins_pkg;

  localparam int DATA_W  = 32;
  localparam int FRAME_N = 8;
  localparam int CNT_W   = $clog2(FRAME_N);
  localparam int FCNT_W  = CNT_W + 1;

  typedef enum logic {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } ins_load_state_t;

  // One-hot write enable for the slot addressed by the fill counter.
  function automatic logic [FRAME_N-1:0] slot_decode(input logic [CNT_W-1:0] idx);
    logic [FRAME_N-1:0] sel;
    sel      = '0;
    sel[idx] = 1'b1;
    return sel;
  endfunction

  // Thermometer mask of every slot above idx; these are the pad slots of a short frame.
  function automatic logic [FRAME_N-1:0] pad_thermo(input logic [CNT_W-1:0] idx);
    logic [FRAME_N-1:0] mask;
    for (int i = 0; i < FRAME_N; i++) begin
      mask[i] = (i > int'(idx));
    end
    return mask;
  endfunction

endpackage

// File: rtl/ins_loader.sv
// Serial-to-parallel 8-word frame loader feeding the insertion sorter.
// Short frames (s_last with max-value padding) exist only when INS_LOADER_SHORT_FRAME_EN is defined.
//
// state   | meaning
// FILL    | accepting stream words into slots, s_ready=1
// PRESENT | frame held stable on f_dat*, f_valid=1, waiting for f_ready
module ins_loader
  import ins_pkg::*;
#(
  parameter int                DATA_W    = ins_pkg::DATA_W,
  parameter logic [DATA_W-1:0] PAD_VALUE = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] f_dat1,
  output logic [DATA_W-1:0] f_dat2,
  output logic [DATA_W-1:0] f_dat3,
  output logic [DATA_W-1:0] f_dat4,
  output logic [DATA_W-1:0] f_dat5,
  output logic [DATA_W-1:0] f_dat6,
  output logic [DATA_W-1:0] f_dat7,
  output logic [DATA_W-1:0] f_dat8,
  output logic [3:0]        f_count,
  output logic              f_valid,
  input  logic              f_ready
);

  ins_load_state_t   state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] slot [FRAME_N];
  logic [FCNT_W-1:0] count_q;

  logic               accept;
  logic               last_word;
  logic               frame_end;
  logic [FRAME_N-1:0] wr_sel;

  // Handshake flags come straight from the state register, never from inputs.
  assign s_ready = (state == FILL);
  assign f_valid = (state == PRESENT);

  assign accept    = s_valid & s_ready;
  assign wr_sel    = slot_decode(cnt);
  assign frame_end = (cnt == CNT_W'(FRAME_N - 1)) | last_word;

`ifdef INS_LOADER_SHORT_FRAME_EN
  logic [FRAME_N-1:0] pad_sel;

  assign last_word = s_last;
  assign pad_sel   = last_word ? pad_thermo(cnt) : '0;
`else
  logic [DATA_W:0] unused_cfg;

  assign last_word  = 1'b0;
  assign unused_cfg = {s_last, PAD_VALUE};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FILL;
      cnt     <= '0;
      count_q <= '0;
      for (int i = 0; i < FRAME_N; i++) begin
        slot[i] <= '0;
      end
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            for (int i = 0; i < FRAME_N; i++) begin
              if (wr_sel[i]) begin
                slot[i] <= s_data;
`ifdef INS_LOADER_SHORT_FRAME_EN
              end else if (pad_sel[i]) begin
                slot[i] <= PAD_VALUE;
`endif
              end
            end
            if (frame_end) begin
              state   <= PRESENT;
              count_q <= {1'b0, cnt} + FCNT_W'(1);
              cnt     <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        PRESENT: begin
          // The handshake cycle is a bubble: no word is taken on this edge.
          if (f_ready) begin
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign f_dat1  = slot[0];
  assign f_dat2  = slot[1];
  assign f_dat3  = slot[2];
  assign f_dat4  = slot[3];
  assign f_dat5  = slot[4];
  assign f_dat6  = slot[5];
  assign f_dat7  = slot[6];
  assign f_dat8  = slot[7];
  assign f_count = count_q;

endmodule

// File: doc/ins_loader.md
# ins_loader

Serial-to-parallel frame loader that sits directly upstream of the 8-input insertion sorter. It accepts 32-bit words one at a time over a valid/ready stream and packs them into an 8-word frame. It presents the frame on eight parallel buses wired straight to the sorter's `in1`..`in8`, and holds the frame stable until the downstream handshake completes. Short frames are padded with the maximum value, so padding sorts to the top slots.

## Interface
Parameters:
- `DATA_W`, default 32: word width; must match the sorter.
- `PAD_VALUE`, default all-ones of `DATA_W`: value written into unfilled slots of a short frame.

Ports:
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `rst`, input, 1 bit: reset; synchronous and active-high.
- `s_data`, input, `DATA_W` bits: stream word.
- `s_valid`, input, 1 bit: `s_data` is valid.
- `s_last`, input, 1 bit: current word ends the frame. Used only with the configuration macro.
- `s_ready`, output, 1 bit: loader can accept a word.
- `f_dat1`..`f_dat8`, output, `DATA_W` bits each: frame slots 1..8, in arrival order.
- `f_count`, output, 4 bits: number of real (non-pad) words in the frame, 1..8.
- `f_valid`, output, 1 bit: frame is complete and stable.
- `f_ready`, input, 1 bit: downstream takes the frame.

## Operation
- States:
  - FILL: `s_ready`=1, `f_valid`=0.
  - PRESENT: `s_ready`=0, `f_valid`=1.
- Internal slot counter `cnt`, 3 bits, range 0..7, equal to the index of the next slot to write.
- Accept occurs when `s_valid & s_ready`. On accept, slot `cnt+1` takes `s_data`.
  - If `cnt`==7 or the word is last: go to PRESENT, `f_count` = `cnt+1`, `cnt` returns to 0.
  - Otherwise `cnt` increments.
- Short frame: when a last word is accepted at `cnt`<7, slots `cnt+2`..8 are loaded with `PAD_VALUE` in the same edge.
- `s_last` asserted on the 8th word behaves exactly like a full frame; no padding is applied.
- In PRESENT, `f_dat*` and `f_count` are held constant. On `f_valid & f_ready`, go to FILL.
- No accept occurs in the same cycle as the frame handshake; this leaves one bubble cycle. Throughput is at most one frame per 9 cycles.
- `s_data` and `s_last` are ignored whenever `s_ready`=0. `f_ready` is ignored in FILL.
- Reset values:
  - State FILL, `cnt`=0.
  - `f_valid`=0, `f_count`=0.
  - `f_dat1`..`f_dat8` = 0.
  - `s_ready`=1 from the first cycle after reset deasserts.
- Reset during FILL or PRESENT discards the partial or pending frame. The next accepted word lands in slot 1.

## Timing
- `s_ready` and `f_valid` are decoded from the state register, with no combinational path from inputs.
- All `f_*` outputs are registered.
- `f_valid` rises on the edge that accepts the final word; it is visible in the following cycle.
- Latency: final word accepted at edge N → frame visible after N. The sorter registers it at edge N+1 and outputs the sorted frame at N+2.
- `f_valid` falls on the edge where `f_ready` is sampled high. `s_ready` rises in that same cycle.
- Without downstream backpressure (`f_ready` tied 1), `f_valid` is a one-cycle pulse.

## Configuration
- Macro `INS_LOADER_SHORT_FRAME_EN`.
  - Defined: `s_last` is honoured, with padding and `f_count` as described above.
  - Undefined: `s_last` is ignored, every frame is exactly 8 words, `f_count` is constant 8, and the pad logic is not built.

## Structure
- Shared package `ins_pkg` holds:
  - `DATA_W` default and `FRAME_N`=8.
  - Enum `ins_load_state_t` {FILL, PRESENT}.
  - The sorter uses the same package.
- Single module; a sub-module is not natural here. Slot writes are a decoded enable per slot driven by `cnt`. The pad mask is a thermometer decode of `cnt`.

## Test plan
- Full frame: accept 8,7,6,5,4,3,2,1 back-to-back with `f_ready`=1 → `f_dat1..8`=8..1, `f_count`=8, `f_valid` high exactly 1 cycle after the 8th accept, `s_ready` low for that cycle.
- Short frame (macro on): accept 0x10, 0x30, 0x20 with `s_last` on 0x20 → `f_dat1..3`=0x10,0x30,0x20, `f_dat4..8`=0xFFFFFFFF, `f_count`=3.
- Backpressure: complete a frame, hold `f_ready`=0 for 10 cycles with `s_valid`=1 → outputs stable, `s_ready`=0, no words consumed. Raise `f_ready` → FILL next cycle; the first new word lands in slot 1.
- Reset mid-fill: accept 5 words, pulse `rst` for 1 cycle, send 8 new words → frame holds only the new words, `f_count`=8.
- `s_last` on the 8th word → identical to the full-frame case, with no pad values.
- Macro off: assert `s_last` on the 3rd word → no frame is produced until the 8th accept; `f_count`=8.
